seq10010_scan_ctrl: RTL

Controller that feeds the 10010 Mealy sequence detector from a parallel word source. It accepts WIDTH-bit words over a valid/ready handshake and serializes each word MSB-first into an embedded 10010 overlapping Mealy detector. It counts detections per word and in total, and reports each word's result with a one-cycle done pulse. It sits between a word-oriented producer (bus/register interface) and the bit-serial detector datapath.

---
 rtl/seq10010_scan_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/seq10010_scan_ctrl.sv
// Word-to-serial scan controller feeding an overlapping 10010 Mealy detector.
// Words are shifted MSB-first; detections are counted per word and in total.
module seq10010_scan_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [WIDTH-1:0] data,
    input  logic             clr,
    output logic             ready,
    output logic             busy,
    output logic             j_out,
    output logic             match,
    output logic [3:0]       word_cnt,
    output logic [15:0]      total_cnt,
    output logic             done
);

    localparam int unsigned IDX_W = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;

    localparam logic [2:0] D_S0 = 3'd0;
    localparam logic [2:0] D_S1 = 3'd1;
    localparam logic [2:0] D_S2 = 3'd2;
    localparam logic [2:0] D_S3 = 3'd3;
    localparam logic [2:0] D_S4 = 3'd4;

    logic [1:0]       state, state_nxt;
    logic [2:0]       det, det_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [3:0]       wc_nxt;
    logic [15:0]      tc_nxt;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            det       <= D_S0;
            sreg      <= '0;
            idx       <= '0;
            word_cnt  <= '0;
            total_cnt <= '0;
        end else begin
            state     <= state_nxt;
            det       <= det_nxt;
            sreg      <= sreg_nxt;
            idx       <= idx_nxt;
            word_cnt  <= wc_nxt;
            total_cnt <= tc_nxt;
        end
    end

    // Next-state, detector step and outputs; the MSB of sreg is the bit on the wire
    always_comb begin
        state_nxt = state;
        det_nxt   = det;
        sreg_nxt  = sreg;
        idx_nxt   = idx;
        wc_nxt    = word_cnt;
        tc_nxt    = total_cnt;
        ready     = 1'b0;
        busy      = 1'b0;
        j_out     = 1'b0;
        match     = 1'b0;
        done      = 1'b0;

        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (clr) begin
                    det_nxt = D_S0;
                    tc_nxt  = '0;
                end
                if (valid) begin
                    sreg_nxt  = data;
                    idx_nxt   = IDX_W'(WIDTH - 1);
                    wc_nxt    = '0;
                    state_nxt = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                busy     = 1'b1;
                j_out    = sreg[WIDTH-1];
                match    = (det == D_S4) && !j_out;
                sreg_nxt = {sreg[WIDTH-2:0], 1'b0};

                case (det)
                    D_S0:    det_nxt = j_out ? D_S1 : D_S0;
                    D_S1:    det_nxt = j_out ? D_S1 : D_S2;
                    D_S2:    det_nxt = j_out ? D_S1 : D_S3;
                    D_S3:    det_nxt = j_out ? D_S4 : D_S0;
                    D_S4:    det_nxt = j_out ? D_S1 : D_S2;
                    default: det_nxt = D_S0;
                endcase

                if (match) begin
                    wc_nxt = word_cnt + 4'd1;
                    tc_nxt = total_cnt + 16'd1;
                end

                if (idx == '0) begin
                    state_nxt = ST_REPORT;
                end else begin
                    idx_nxt = idx - IDX_W'(1);
                end
            end

            ST_REPORT: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
